// File: rtl/uart_rx_cmd_demux.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_demux
//
// Parses host command frames arriving byte by byte from a UART receiver:
//   SYNC, OPCODE, LEN, LEN payload bytes, [CHK]
// The payload is stored in a small buffer. One complete command is then held
// for either master control (opcode[7]=0) or the correlator path
// (opcode[7]=1) until the consumer acknowledges it.
//
// Build option:
//   UART_RX_CHECKSUM_EN  defined   -> frame carries a trailing CHK byte, the
//                                     XOR of OPCODE, LEN and all payload bytes.
//                        undefined -> no CHK byte; the command is presented
//                                     right after the last LEN/payload byte.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   RxD_data_ready  1-cycle strobe, RxD_data valid
//   RxD_data        received byte
//   cmd_valid       complete command held until cmd_ack
//   cmd_ack         consumer accepts the command (used only while cmd_valid)
//   cmd_dst         0 = master control, 1 = correlator
//   cmd_opcode      opcode of the held command
//   cmd_len         payload length of the held command
//   pl_rd_addr      payload buffer read address
//   pl_rd_data      buffer[pl_rd_addr], combinational read
//   frame_err       1-cycle pulse: bad LEN, bad CHK or inter-byte timeout
//   overrun         1-cycle pulse: byte arrived while a command was pending
// -----------------------------------------------------------------------------
module uart_rx_cmd_demux #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_PAYLOAD = 16,
  parameter int         AW          = 4,
  parameter int         TIMEOUT     = 50000,
  parameter int         TO_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RxD_data_ready,
  input  logic [7:0]    RxD_data,
  output logic          cmd_valid,
  input  logic          cmd_ack,
  output logic          cmd_dst,
  output logic [7:0]    cmd_opcode,
  output logic [AW:0]   cmd_len,
  input  logic [AW-1:0] pl_rd_addr,
  output logic [7:0]    pl_rd_data,
  output logic          frame_err,
  output logic          overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_LEN,
    S_PAY,
    S_CHK,
    S_HOLD
  } state_t;

  localparam logic [7:0]      MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  // Where the frame goes after the last LEN/payload byte. Without a checksum
  // the command is complete at that point, so cmd_valid rises right away.
`ifdef UART_RX_CHECKSUM_EN
  localparam state_t S_AFTER_PAY  = S_CHK;
  localparam logic   HOLD_ON_LAST = 1'b0;
`else
  localparam state_t S_AFTER_PAY  = S_HOLD;
  localparam logic   HOLD_ON_LAST = 1'b1;
`endif

  state_t          state_q;
  logic            cmd_valid_q;
  logic            cmd_dst_q;
  logic [7:0]      cmd_opcode_q;
  logic [AW:0]     cmd_len_q;
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     wr_ptr_d;
  logic [TO_W-1:0] to_cnt_q;
  logic            frame_err_q;
  logic            overrun_q;
`ifdef UART_RX_CHECKSUM_EN
  logic [7:0]      chk_q;
`endif

  logic [7:0] buf_mem [2**AW];

  logic in_frame;
  logic to_expired;
  logic buf_we;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_frame   = 1'b0;
    to_expired = 1'b0;
    buf_we     = 1'b0;
    wr_ptr_d   = wr_ptr_q + 1'b1;
    in_frame   = state_q inside {S_OPC, S_LEN, S_PAY, S_CHK};
    // A strobe in the same cycle wins over the timeout.
    to_expired = in_frame && !RxD_data_ready && (to_cnt_q == TO_LAST);
    buf_we     = (state_q == S_PAY) && RxD_data_ready;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_dst_q    <= 1'b0;
      cmd_opcode_q <= 8'h00;
      cmd_len_q    <= '0;
      wr_ptr_q     <= '0;
      to_cnt_q     <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_CHECKSUM_EN
      chk_q        <= 8'h00;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Inter-byte watchdog: runs only while a frame is being received.
      if (in_frame && !RxD_data_ready && !to_expired) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end else begin
        to_cnt_q <= '0;
      end

      if (to_expired) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (RxD_data_ready && RxD_data == SYNC_BYTE) begin
              state_q <= S_OPC;
            end
          end

          S_OPC: begin
            if (RxD_data_ready) begin
              cmd_opcode_q <= RxD_data;
              cmd_dst_q    <= RxD_data[7];
`ifdef UART_RX_CHECKSUM_EN
              chk_q        <= RxD_data;
`endif
              state_q      <= S_LEN;
            end
          end

          S_LEN: begin
            if (RxD_data_ready) begin
              if (RxD_data > MAX_LEN) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                cmd_len_q <= RxD_data[AW:0];
                wr_ptr_q  <= '0;
`ifdef UART_RX_CHECKSUM_EN
                chk_q     <= chk_q ^ RxD_data;
`endif
                if (RxD_data == 8'h00) begin
                  cmd_valid_q <= HOLD_ON_LAST;
                  state_q     <= S_AFTER_PAY;
                end else begin
                  state_q <= S_PAY;
                end
              end
            end
          end

          S_PAY: begin
            if (RxD_data_ready) begin
              wr_ptr_q <= wr_ptr_d;
`ifdef UART_RX_CHECKSUM_EN
              chk_q    <= chk_q ^ RxD_data;
`endif
              if (wr_ptr_d == cmd_len_q) begin
                cmd_valid_q <= HOLD_ON_LAST;
                state_q     <= S_AFTER_PAY;
              end
            end
          end

`ifdef UART_RX_CHECKSUM_EN
          S_CHK: begin
            if (RxD_data_ready) begin
              if (RxD_data == chk_q) begin
                cmd_valid_q <= 1'b1;
                state_q     <= S_HOLD;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end
            end
          end
`endif

          S_HOLD: begin
            // Bytes arriving while a command is pending are dropped, even in
            // the ack cycle, so such a byte can never start a new frame.
            if (RxD_data_ready) begin
              overrun_q <= 1'b1;
            end
            if (cmd_ack) begin
              cmd_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: the payload buffer has no reset; its contents are only meaningful
  // for the first cmd_len entries of a held command.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr_q[AW-1:0]] <= RxD_data;
    end
  end

  assign pl_rd_data = buf_mem[pl_rd_addr];
  assign cmd_valid  = cmd_valid_q;
  assign cmd_dst    = cmd_dst_q;
  assign cmd_opcode = cmd_opcode_q;
  assign cmd_len    = cmd_len_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cmd_demux.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd_demux
//
// Directed bench for uart_rx_cmd_demux. Frames are built from opcode, length
// and payload; the expected command is queued when a frame is driven and
// checked against the DUT when cmd_valid is presented. The CHK byte is sent
// only when UART_RX_CHECKSUM_EN is defined, matching the DUT build.
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd_demux;

  localparam int         AW       = 4;
  localparam int         TIMEOUT  = 40;
  localparam logic [7:0] SYNC     = 8'hA5;

  typedef struct packed {
    logic         dst;
    logic [7:0]   op;
    logic [AW:0]  len;
    logic [127:0] pl;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          RxD_data_ready;
  logic [7:0]    RxD_data;
  logic          cmd_valid;
  logic          cmd_ack;
  logic          cmd_dst;
  logic [7:0]    cmd_opcode;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] pl_rd_addr;
  logic [7:0]    pl_rd_data;
  logic          frame_err;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  cmd_t exp_q[$];

  uart_rx_cmd_demux #(
    .SYNC_BYTE  (SYNC),
    .MAX_PAYLOAD(16),
    .AW         (AW),
    .TIMEOUT    (TIMEOUT),
    .TO_W       (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .RxD_data_ready(RxD_data_ready),
    .RxD_data      (RxD_data),
    .cmd_valid     (cmd_valid),
    .cmd_ack       (cmd_ack),
    .cmd_dst       (cmd_dst),
    .cmd_opcode    (cmd_opcode),
    .cmd_len       (cmd_len),
    .pl_rd_addr    (pl_rd_addr),
    .pl_rd_data    (pl_rd_data),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One-cycle strobe; returns on the falling edge after the capturing edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    RxD_data       = b;
    RxD_data_ready = 1'b1;
    @(negedge clk);
    RxD_data_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] op, input int len, input logic [127:0] pl,
                            input bit bad_chk, input bit push);
    logic [7:0] chk;
    cmd_t       c;
    chk = op ^ 8'(len);
    if (push) begin
      c.dst = op[7];
      c.op  = op;
      c.len = (AW+1)'(len);
      c.pl  = pl;
      exp_q.push_back(c);
    end
    send_byte(SYNC);
    send_byte(op);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(pl[i*8 +: 8]);
      chk = chk ^ pl[i*8 +: 8];
    end
`ifdef UART_RX_CHECKSUM_EN
    send_byte(bad_chk ? ~chk : chk);
`endif
  endtask

  task automatic do_ack();
    @(negedge clk);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    check("valid_after_ack", cmd_valid, 1'b0);
  endtask

  // Called right after the last byte of a frame: cmd_valid must already be up.
  task automatic expect_cmd(input bit ack);
    cmd_t c;
    check("valid_latency", cmd_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      c = exp_q.pop_front();
      check("cmd_dst", cmd_dst, c.dst);
      check("cmd_opcode", cmd_opcode, c.op);
      check("cmd_len", cmd_len, c.len);
      for (int i = 0; i < int'(c.len); i++) begin
        pl_rd_addr = AW'(i);
        #1;
        check($sformatf("payload[%0d]", i), pl_rd_data, c.pl[i*8 +: 8]);
      end
    end
    if (ack) do_ack();
  endtask

  initial begin
    int fe0;
    int ov0;
    logic [127:0] pl;

    rst            = 1'b1;
    RxD_data_ready = 1'b0;
    RxD_data       = 8'h00;
    cmd_ack        = 1'b0;
    pl_rd_addr     = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state.
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_dst", cmd_dst, 1'b0);
    check("rst_cmd_opcode", cmd_opcode, 8'h00);
    check("rst_cmd_len", cmd_len, '0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);

    // Master-control command with two payload bytes.
    send_frame(8'h01, 2, {112'h0, 8'h22, 8'h11}, 1'b0, 1'b1);
    expect_cmd(1'b1);

    // Correlator command with empty payload.
    send_frame(8'h85, 0, '0, 1'b0, 1'b1);
    expect_cmd(1'b1);

`ifdef UART_RX_CHECKSUM_EN
    // Bad checksum: error pulse, nothing presented.
    fe0 = fe_cnt;
    send_frame(8'h01, 1, {120'h0, 8'hFF}, 1'b1, 1'b0);
    idle(2);
    check("badchk_frame_err", fe_cnt, fe0 + 1);
    check("badchk_no_valid", cmd_valid, 1'b0);
`endif

    // Good frame with SYNC inside the payload: it is data, not a restart.
    send_frame(8'h02, 3, {104'h0, 8'h7E, 8'h3C, 8'hA5}, 1'b0, 1'b1);
    expect_cmd(1'b1);

    // LEN above the limit: error right at the LEN strobe, then 3C ignored.
    fe0 = fe_cnt;
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h11);
    check("len17_frame_err_pulse", frame_err, 1'b1);
    send_byte(8'h3C);
    idle(3);
    check("len17_frame_err_count", fe_cnt, fe0 + 1);
    check("len17_no_valid", cmd_valid, 1'b0);

    // Maximum payload length, random data.
    for (int i = 0; i < 16; i++) pl[i*8 +: 8] = 8'($urandom_range(0, 255));
    send_frame(8'h90, 16, pl, 1'b0, 1'b1);
    expect_cmd(1'b1);

    // Bytes spaced just inside the timeout are still accepted.
    fe0 = fe_cnt;
    exp_q.push_back('{dst: 1'b0, op: 8'h33, len: 5'd1, pl: {120'h0, 8'h44}});
    send_byte(SYNC);
    idle(TIMEOUT - 2);
    send_byte(8'h33);
    idle(TIMEOUT - 2);
    send_byte(8'h01);
    idle(TIMEOUT - 2);
`ifdef UART_RX_CHECKSUM_EN
    send_byte(8'h44);
    idle(TIMEOUT - 2);
    send_byte(8'h33 ^ 8'h01 ^ 8'h44);
`else
    send_byte(8'h44);
`endif
    expect_cmd(1'b1);
    check("slow_no_frame_err", fe_cnt, fe0);

    // Timeout mid-frame: exactly one error pulse, no command.
    fe0 = fe_cnt;
    send_byte(SYNC);
    send_byte(8'h01);
    idle(TIMEOUT - 3);
    check("timeout_not_early", fe_cnt, fe0);
    idle(13);
    check("timeout_one_pulse", fe_cnt, fe0 + 1);
    check("timeout_no_valid", cmd_valid, 1'b0);

    // Back in IDLE after the timeout.
    send_frame(8'h07, 1, {120'h0, 8'h5A}, 1'b0, 1'b1);
    expect_cmd(1'b0);

    // Overrun while pending, then a byte coincident with ack.
    ov0 = ov_cnt;
    send_byte(8'h5A);
    check("ovr_first_pulse", ov_cnt, ov0 + 1);
    check("ovr_still_valid", cmd_valid, 1'b1);
    check("ovr_opcode_stable", cmd_opcode, 8'h07);
    @(negedge clk);
    cmd_ack        = 1'b1;
    RxD_data       = SYNC;
    RxD_data_ready = 1'b1;
    @(negedge clk);
    cmd_ack        = 1'b0;
    RxD_data_ready = 1'b0;
    check("ovr_ack_valid_low", cmd_valid, 1'b0);
    check("ovr_second_pulse", ov_cnt, ov0 + 2);
    // If that A5 had been taken as SYNC, these would complete a command.
    fe0 = fe_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    idle(3);
    check("ovr_sync_not_taken", cmd_valid, 1'b0);
    check("ovr_no_more_overrun", ov_cnt, ov0 + 2);
    check("ovr_no_frame_err", fe_cnt, fe0);

    // Reset mid-frame aborts silently.
    fe0 = fe_cnt;
    send_byte(SYNC);
    send_byte(8'h81);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_opcode", cmd_opcode, 8'h00);
    check("midrst_dst", cmd_dst, 1'b0);
    check("midrst_len", cmd_len, '0);
    idle(2);
    check("midrst_no_frame_err", fe_cnt, fe0);
    send_frame(8'h0C, 2, {112'h0, 8'hBE, 8'hEF}, 1'b0, 1'b1);
    expect_cmd(1'b1);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
